// File: rtl/tdm_demux_if.sv
// ============================================================================
// tdm_demux_if : serial TDM input and recovered parallel frame bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface tdm_demux_if #(
   parameter int CHANNELS = 8,
   parameter int SEL_W    = 3
);
   logic                din;
   logic                fs;
   logic                en;
   logic [CHANNELS-1:0] y;
   logic                frame_valid;
   logic [SEL_W-1:0]    slot;
   logic                locked;
   logic                sync_err;

   modport master (
      output din, fs, en,
      input  y, frame_valid, slot, locked, sync_err
   );

   modport slave (
      input  din, fs, en,
      output y, frame_valid, slot, locked, sync_err
   );
endinterface

`default_nettype wire

// File: rtl/tdm_demux.sv
// ============================================================================
// tdm_demux : recovers CHANNELS single-bit channels from a frame-synced TDM stream
// Rev 1.0
// ============================================================================
`default_nettype none

module tdm_demux #(
   parameter int CHANNELS = 8,
   parameter int SEL_W    = 3
) (
   input  wire          clk,
   input  wire          rst_n,
   tdm_demux_if.slave   bus
);

   typedef enum logic [0:0] {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(CHANNELS - 1);

   state_t              state_q,       state_d;
   logic [SEL_W-1:0]    slot_q,        slot_d;
   logic [CHANNELS-1:0] shadow_q,      shadow_d;
   logic [CHANNELS-1:0] y_q,           y_d;
   logic                frame_valid_q, frame_valid_d;
   logic                sync_err_q,    sync_err_d;

   always_comb begin
      state_d       = state_q;
      slot_d        = slot_q;
      shadow_d      = shadow_q;
      y_d           = y_q;
      frame_valid_d = 1'b0;
      sync_err_d    = 1'b0;

      if (bus.en) begin
         case (state_q)
            HUNT: begin
               if (bus.fs) begin
                  shadow_d[0] = bus.din;
                  slot_d      = SEL_W'(1);
                  state_d     = LOCKED;
               end
            end
            LOCKED: begin
               // fs always restarts the frame; off slot 0 it is also an error
               if (bus.fs) begin
                  sync_err_d  = (slot_q != '0);
                  shadow_d[0] = bus.din;
                  slot_d      = SEL_W'(1);
               end else if (slot_q == '0) begin
                  sync_err_d = 1'b1;
                  state_d    = HUNT;
               end else if (slot_q == LAST_SLOT) begin
                  y_d           = {bus.din, shadow_q[CHANNELS-2:0]};
                  frame_valid_d = 1'b1;
                  slot_d        = '0;
               end else begin
                  shadow_d[slot_q] = bus.din;
                  slot_d           = slot_q + SEL_W'(1);
               end
            end
            default: state_d = HUNT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= HUNT;
         slot_q        <= '0;
         shadow_q      <= '0;
         y_q           <= '0;
         frame_valid_q <= 1'b0;
         sync_err_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         slot_q        <= slot_d;
         shadow_q      <= shadow_d;
         y_q           <= y_d;
         frame_valid_q <= frame_valid_d;
         sync_err_q    <= sync_err_d;
      end
   end

   assign bus.y           = y_q;
   assign bus.frame_valid = frame_valid_q;
   assign bus.slot        = slot_q;
   assign bus.locked      = (state_q == LOCKED);
   assign bus.sync_err    = sync_err_q;

endmodule

`default_nettype wire
